rv32i_decode_stage: RTL and testbench

Registered RV32I instruction decode stage, sitting between the instruction memory fetch path and the execute stage of the core. It takes raw 32-bit instruction words with their PC, splits them into register fields, reconstructs the sign-extended immediate for every RV32I format, classifies the instruction and flags illegal encodings. A 2-entry skid buffer with valid/ready handshakes on both sides decouples fetch from execute. A saturating counter tracks illegal instructions accepted.

---
 rtl/rv32i_decode_stage.sv | 168 ++++++++++++++++
 tb/tb_rv32i_decode_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_decode_stage.sv
// RV32I registered decode stage: combinational decode of the incoming word,
// 2-entry skid buffer between fetch and execute, saturating illegal counter.
//
// state | meaning
// EMPTY | no entries held, head outputs invalid
// ONE   | head entry valid in slot 0, slot 1 free
// FULL  | both slots valid, slot 1 is behind the head
module rv32i_decode_stage #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [3:0]           out_class,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [2:0]           out_funct3,
    output logic                 out_funct7b5,
    output logic [31:0]          out_imm,
    output logic                 out_illegal,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] imm;
    } entry_t;

    localparam logic [3:0] CLS_ILL = 4'hF;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t      r_state, w_state_nxt;
    entry_t      r_slot0, r_slot1, w_dec;
    logic        w_push, w_pop;
    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [CNT_WIDTH-1:0] r_cnt;

    assign w_op = in_instr[6:0];
    assign w_f3 = in_instr[14:12];
    assign w_f7 = in_instr[31:25];

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'h000};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Decode the incoming word; anything not matched stays ILLEGAL with zeroed fields
    always_comb begin
        w_dec     = '0;
        w_dec.pc  = in_pc;
        w_dec.cls = CLS_ILL;
        case (w_op)
            7'h33: if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                w_dec.cls = 4'd0; w_dec.rd = in_instr[11:7]; w_dec.rs1 = in_instr[19:15];
                w_dec.rs2 = in_instr[24:20]; w_dec.f3 = w_f3; w_dec.f7b5 = in_instr[30];
            end
            7'h13: if ((w_f3 == 3'b001 && w_f7 == 7'h00) ||
                       (w_f3 == 3'b101 && (w_f7 == 7'h00 || w_f7 == 7'h20)) ||
                       (w_f3 != 3'b001 && w_f3 != 3'b101)) begin
                w_dec.cls = 4'd1; w_dec.rd = in_instr[11:7]; w_dec.rs1 = in_instr[19:15];
                w_dec.f3 = w_f3; w_dec.f7b5 = (w_f3 == 3'b101) && in_instr[30]; w_dec.imm = w_imm_i;
            end
            7'h03: if (w_f3 != 3'b011 && w_f3 != 3'b110 && w_f3 != 3'b111) begin
                w_dec.cls = 4'd2; w_dec.rd = in_instr[11:7]; w_dec.rs1 = in_instr[19:15];
                w_dec.f3 = w_f3; w_dec.imm = w_imm_i;
            end
            7'h23: if (w_f3 <= 3'b010) begin
                w_dec.cls = 4'd3; w_dec.rs1 = in_instr[19:15]; w_dec.rs2 = in_instr[24:20];
                w_dec.f3 = w_f3; w_dec.imm = w_imm_s;
            end
            7'h63: if (w_f3 != 3'b010 && w_f3 != 3'b011) begin
                w_dec.cls = 4'd4; w_dec.rs1 = in_instr[19:15]; w_dec.rs2 = in_instr[24:20];
                w_dec.f3 = w_f3; w_dec.imm = w_imm_b;
            end
            7'h37: begin
                w_dec.cls = 4'd5; w_dec.rd = in_instr[11:7]; w_dec.imm = w_imm_u;
            end
            7'h17: begin
                w_dec.cls = 4'd6; w_dec.rd = in_instr[11:7]; w_dec.imm = w_imm_u;
            end
            7'h6F: begin
                w_dec.cls = 4'd7; w_dec.rd = in_instr[11:7]; w_dec.imm = w_imm_j;
            end
            7'h67: if (w_f3 == 3'b000) begin
                w_dec.cls = 4'd8; w_dec.rd = in_instr[11:7]; w_dec.rs1 = in_instr[19:15];
                w_dec.imm = w_imm_i;
            end
            default: ;
        endcase
    end

    // Buffer occupancy: handshake outputs depend only on state and reset, never on out_ready
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state != FULL) && !reset;
        out_valid   = (r_state != EMPTY) && !reset;
        w_pop       = out_valid && out_ready;
        w_push      = in_valid && in_ready && !flush;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (w_push) w_state_nxt = ONE;
                ONE:     if (w_push && !w_pop) w_state_nxt = FULL;
                         else if (!w_push && w_pop) w_state_nxt = EMPTY;
                FULL:    if (w_pop) w_state_nxt = ONE;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= EMPTY;
        else       r_state <= w_state_nxt;
    end

    // Slot storage: slot 0 is always the head; slot 1 shifts forward on a pop from FULL
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            if (r_state == FULL && w_pop) r_slot0 <= r_slot1;
            if (w_push) begin
                if (r_state == EMPTY || (r_state == ONE && w_pop)) r_slot0 <= w_dec;
                else                                               r_slot1 <= w_dec;
            end
        end
    end

    // Saturating count of accepted illegal words
    always_ff @(posedge clk) begin
        if (reset)                                                     r_cnt <= '0;
        else if (w_push && w_dec.cls == CLS_ILL && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end

    assign out_pc        = r_slot0.pc;
    assign out_class     = r_slot0.cls;
    assign out_rd        = r_slot0.rd;
    assign out_rs1       = r_slot0.rs1;
    assign out_rs2       = r_slot0.rs2;
    assign out_funct3    = r_slot0.f3;
    assign out_funct7b5  = r_slot0.f7b5;
    assign out_imm       = r_slot0.imm;
    assign out_illegal   = (r_slot0.cls == CLS_ILL);
    assign illegal_count = r_cnt;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Randomised and directed bench for rv32i_decode_stage, with a queue-based
// reference model and a second instance built with a 2-bit illegal counter.
module tb_rv32i_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid, out_funct7b5, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [3:0]  out_class;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [15:0] illegal_count;

    logic        s_in_ready, s_out_valid, s_f7b5, s_illegal;
    logic [31:0] s_pc, s_imm;
    logic [3:0]  s_class;
    logic [4:0]  s_rd, s_rs1, s_rs2;
    logic [2:0]  s_f3;
    logic [1:0]  s_count;

    rv32i_decode_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_imm(out_imm), .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    rv32i_decode_stage #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_pc), .out_class(s_class), .out_rd(s_rd), .out_rs1(s_rs1),
        .out_rs2(s_rs2), .out_funct3(s_f3), .out_funct7b5(s_f7b5),
        .out_imm(s_imm), .out_illegal(s_illegal), .illegal_count(s_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } txn_t;

    typedef struct {
        int          cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] imm;
    } ref_t;

    txn_t q[$];
    int   m_cnt, m_cnt2;
    int   checks, errors;
    logic acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int sext(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        return v;
    endfunction

    // Reference decode from the ISA rules: legality first, then which fields each format carries
    function automatic ref_t ref_dec(input logic [31:0] w);
        ref_t d;
        int   op, f3, f7, cls;
        bit   ok;
        op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
        d = '{cls: 15, rd: 0, rs1: 0, rs2: 0, f3: 0, f7b5: 0, imm: 0};
        ok = 1; cls = 15;
        case (op)
            'h33: begin cls = 0; ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5)); end
            'h13: begin cls = 1; if (f3 == 1) ok = (f7 == 0); else if (f3 == 5) ok = (f7 == 0 || f7 == 'h20); end
            'h03: begin cls = 2; ok = !(f3 == 3 || f3 == 6 || f3 == 7); end
            'h23: begin cls = 3; ok = (f3 < 3); end
            'h63: begin cls = 4; ok = !(f3 == 2 || f3 == 3); end
            'h37: cls = 5;
            'h17: cls = 6;
            'h6F: cls = 7;
            'h67: begin cls = 8; ok = (f3 == 0); end
            default: ok = 0;
        endcase
        if (!ok) return d;
        d.cls = cls;
        if (cls != 3 && cls != 4)            d.rd  = w[11:7];
        if (cls != 5 && cls != 6 && cls != 7) d.rs1 = w[19:15];
        if (cls == 0 || cls == 3 || cls == 4) d.rs2 = w[24:20];
        if (cls < 5 || cls == 8)              d.f3  = w[14:12];
        d.f7b5 = w[30] && (cls == 0 || (cls == 1 && f3 == 5));
        case (cls)
            1, 2, 8: d.imm = 32'(sext(int'(w[31:20]), 12));
            3:       d.imm = 32'(sext(int'(w[31:25]) * 32 + int'(w[11:7]), 12));
            4:       d.imm = 32'(sext(int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13));
            5, 6:    d.imm = 32'(int'(w[31:12]) * 4096);
            7:       d.imm = 32'(sext(int'(w[31]) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21));
            default: d.imm = 0;
        endcase
        return d;
    endfunction

    task automatic model_edge();
        bit push, pop;
        txn_t t;
        if (reset) begin
            q.delete(); m_cnt = 0; m_cnt2 = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            push = in_valid && q.size() < 2;
            pop  = q.size() > 0 && out_ready;
            if (pop) void'(q.pop_front());
            if (push) begin
                t.instr = in_instr; t.pc = in_pc;
                q.push_back(t);
                if (ref_dec(in_instr).cls == 15) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
    endtask

    task automatic compare_all();
        ref_t d;
        chk("in_ready", 32'(in_ready), 32'(!reset && q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(!reset && q.size() > 0));
        if (!reset && q.size() > 0) begin
            d = ref_dec(q[0].instr);
            chk("head_pc", out_pc, q[0].pc);
            chk("head_class", 32'(out_class), 32'(d.cls));
            chk("head_rd", 32'(out_rd), 32'(d.rd));
            chk("head_rs1", 32'(out_rs1), 32'(d.rs1));
            chk("head_rs2", 32'(out_rs2), 32'(d.rs2));
            chk("head_funct3", 32'(out_funct3), 32'(d.f3));
            chk("head_funct7b5", 32'(out_funct7b5), 32'(d.f7b5));
            chk("head_imm", out_imm, d.imm);
            chk("head_illegal", 32'(out_illegal), 32'(d.cls == 15));
        end
        chk("illegal_count", 32'(illegal_count), 32'(m_cnt));
        chk("illegal_count_w2", 32'(s_count), 32'(m_cnt2));
    endtask

    task automatic step(input logic rst, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, output logic accepted);
        @(negedge clk);
        reset = rst; in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
        #1 accepted = v && in_ready && !fl && !rst;
        @(posedge clk);
        model_edge();
        #1 compare_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [9];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 8)];
        if ($urandom_range(0, 1) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    initial begin
        int idx;
        logic [31:0] bp_pc [3];
        checks = 0; errors = 0; m_cnt = 0; m_cnt2 = 0;
        reset = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 1, 0, acc);
        chk("rst_pc", out_pc, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_class", 32'(out_class), 0);
        chk("rst_ready", 32'(in_ready), 1);

        step(0, 1, 32'h00418293, 32'h0, 1, 0, acc);
        chk("addi_class", 32'(out_class), 1); chk("addi_rd", 32'(out_rd), 5);
        chk("addi_rs1", 32'(out_rs1), 3);     chk("addi_rs2", 32'(out_rs2), 0);
        chk("addi_imm", out_imm, 4);          chk("addi_cnt", 32'(illegal_count), 0);
        step(0, 1, 32'h00628A63, 32'h4, 1, 0, acc);
        chk("beq_class", 32'(out_class), 4); chk("beq_rs1", 32'(out_rs1), 5);
        chk("beq_rs2", 32'(out_rs2), 6);     chk("beq_rd", 32'(out_rd), 0);
        chk("beq_imm", out_imm, 20);
        step(0, 1, 32'h100000EF, 32'h8, 1, 0, acc);
        chk("jal_class", 32'(out_class), 7); chk("jal_rd", 32'(out_rd), 1); chk("jal_imm", out_imm, 256);
        step(0, 1, 32'h123452B7, 32'hC, 1, 0, acc);
        chk("lui_class", 32'(out_class), 5); chk("lui_imm", out_imm, 32'h12345000);
        step(0, 1, 32'h409403B3, 32'h10, 1, 0, acc);
        chk("sub_class", 32'(out_class), 0); chk("sub_f7b5", 32'(out_funct7b5), 1);
        step(0, 1, 32'h40119493, 32'h14, 1, 0, acc);
        chk("slli_bad_class", 32'(out_class), 15); chk("slli_bad_imm", out_imm, 0);
        step(0, 1, 32'h00000000, 32'h18, 1, 0, acc);
        chk("zero_class", 32'(out_class), 15);
        step(0, 1, 32'hFFFFFFFF, 32'h1C, 1, 0, acc);
        chk("ones_class", 32'(out_class), 15);
        step(0, 0, 0, 0, 1, 0, acc);
        chk("illegal_cnt3", 32'(illegal_count), 3);
        chk("out_valid_drained", 32'(out_valid), 0);

        step(0, 1, 32'h00000000, 32'h20, 1, 0, acc);
        step(0, 1, 32'hFFFFFFFF, 32'h24, 1, 0, acc);
        step(0, 0, 0, 0, 1, 0, acc);
        chk("cnt_wide_5", 32'(illegal_count), 5);
        chk("cnt_sat_3", 32'(s_count), 3);

        bp_pc = '{32'h200, 32'h204, 32'h208};
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'h00418293 + (idx << 7), bp_pc[idx], 0, 0, acc);
            if (acc) idx++;
            if (i == 1) chk("bp_ready_low", 32'(in_ready), 0);
        end
        chk("bp_held", 32'(idx), 2);
        chk("bp_head", out_pc, 32'h200);
        step(0, 1, 32'h00418293 + (idx << 7), bp_pc[idx], 1, 0, acc);
        chk("bp_pop1", out_pc, 32'h204);
        step(0, 1, 32'h00418293 + (idx << 7), bp_pc[idx], 1, 0, acc);
        if (acc) idx++;
        chk("bp_pop2", out_pc, 32'h208);
        step(0, 0, 0, 0, 1, 0, acc);
        chk("bp_empty", 32'(out_valid), 0);

        step(0, 1, 32'h00418293, 32'h300, 0, 0, acc);
        step(0, 1, 32'h00628A63, 32'h304, 0, 0, acc);
        chk("fl_full", 32'(in_ready), 0);
        step(0, 1, 32'h00000000, 32'h308, 1, 1, acc);
        chk("fl_valid", 32'(out_valid), 0);
        chk("fl_cnt", 32'(illegal_count), 5);
        step(0, 0, 0, 0, 1, 0, acc);
        chk("fl_still_empty", 32'(out_valid), 0);

        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, rand_instr(),
                 32'($urandom) & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0, acc);

        step(0, 1, 32'hFFFFFFFF, 32'h400, 0, 0, acc);
        step(0, 1, 32'h00000000, 32'h404, 0, 0, acc);
        step(1, 1, 32'hFFFFFFFF, 32'h408, 0, 0, acc);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_cnt", 32'(illegal_count), 0);
        step(0, 0, 0, 0, 1, 0, acc);
        chk("post_rst_ready", 32'(in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
